// File: rtl/pcs_rx_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pcs_rx_link_ctrl_if
// Brief    : Receive-side sync header / link status bundle for pcs_rx_link_ctrl
// Revision : 1.0
// ============================================================================
interface pcs_rx_link_ctrl_if #(
    parameter int HDR_WIDTH = 2
);
    logic [HDR_WIDTH-1:0] i_hdr;
    logic                 i_hdr_valid;
    logic                 i_block_lock;
    logic [1:0]           o_state;
    logic                 o_link_up;
    logic                 o_hi_ber;
    logic                 o_retrain;
    logic [7:0]           o_drop_cnt;

    modport slave (
        input  i_hdr, i_hdr_valid, i_block_lock,
        output o_state, o_link_up, o_hi_ber, o_retrain, o_drop_cnt
    );

    modport master (
        output i_hdr, i_hdr_valid, i_block_lock,
        input  o_state, o_link_up, o_hi_ber, o_retrain, o_drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pcs_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pcs_rx_link_ctrl
// Brief    : PCS receive link controller: BER monitor, link qualify FSM, retrain
// Revision : 1.0
// ============================================================================
module pcs_rx_link_ctrl #(
    parameter int HDR_WIDTH       = 2,
    parameter int BER_WINDOW_CYC  = 19531,
    parameter int BER_THRESH      = 16,
    parameter int LINK_UP_HDRS    = 1024,
    parameter int RETRAIN_TIMEOUT = 65536
) (
    input  wire                      i_clk,
    input  wire                      i_reset,
    pcs_rx_link_ctrl_if.slave        bus
);
    localparam int TMR_W  = $clog2(BER_WINDOW_CYC) + 1;
    localparam int BAD_W  = $clog2(BER_THRESH) + 1;
    localparam int TMO_W  = $clog2(RETRAIN_TIMEOUT) + 1;
    localparam int QUAL_W = $clog2(LINK_UP_HDRS) + 1;

    localparam logic [TMR_W-1:0]  c_win_end  = TMR_W'(BER_WINDOW_CYC - 1);
    localparam logic [BAD_W-1:0]  c_thresh   = BAD_W'(BER_THRESH);
    localparam logic [TMO_W-1:0]  c_tmo_end  = TMO_W'(RETRAIN_TIMEOUT - 1);
    localparam logic [QUAL_W-1:0] c_qual_end = QUAL_W'(LINK_UP_HDRS - 1);

    typedef enum logic [1:0] {
        ST_DOWN      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_QUALIFY   = 2'd2,
        ST_UP        = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [QUAL_W-1:0]   qual_q, qual_d;
    logic [7:0]          drop_q, drop_d;
    logic                hi_ber_q, hi_ber_d;
    logic                retrain_q, retrain_d;
    logic                link_up_q, link_up_d;

    logic [HDR_WIDTH-1:0] w_hdr;
    logic                 w_sh_valid;
    logic                 w_good;
    logic                 w_invalid;
    logic                 w_lock;
    logic [BAD_W-1:0]     w_bad_nxt;

    assign w_hdr      = bus.i_hdr;
    assign w_sh_valid = ^w_hdr;
    assign w_good     = bus.i_hdr_valid & w_sh_valid;
    assign w_invalid  = bus.i_hdr_valid & ~w_sh_valid;
    assign w_lock     = bus.i_block_lock;
    // Count including this cycle's header, so the window-end evaluation sees it
    assign w_bad_nxt  = (w_invalid && (bad_q != c_thresh)) ? bad_q + BAD_W'(1) : bad_q;

    always_comb begin
        tmr_d    = tmr_q;
        bad_d    = bad_q;
        hi_ber_d = hi_ber_q;
        if (!w_lock) begin
            tmr_d    = '0;
            bad_d    = '0;
            hi_ber_d = 1'b0;
        end else if (tmr_q == c_win_end) begin
            tmr_d    = '0;
            bad_d    = '0;
            hi_ber_d = (w_bad_nxt == c_thresh);
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
            bad_d = w_bad_nxt;
            if (w_bad_nxt == c_thresh) begin
                hi_ber_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        qual_d    = '0;
        retrain_d = 1'b0;
        drop_d    = drop_q;
        case (state_q)
            ST_DOWN: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock) begin
                    state_d = ST_QUALIFY;
                end else if (tmo_q == c_tmo_end) begin
                    retrain_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_QUALIFY: begin
                // Loss of lock / hi_ber outranks a completing good header
                if (!w_lock || hi_ber_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (w_good) begin
                    if (qual_q == c_qual_end) begin
                        state_d = ST_UP;
                    end else begin
                        qual_d = qual_q + QUAL_W'(1);
                    end
                end else begin
                    qual_d = qual_q;
                end
            end
            ST_UP: begin
                if (!w_lock || hi_ber_q) begin
                    state_d = ST_WAIT_LOCK;
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_DOWN;
            end
        endcase
        link_up_d = (state_d == ST_UP);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_DOWN;
            tmr_q     <= '0;
            bad_q     <= '0;
            hi_ber_q  <= 1'b0;
            tmo_q     <= '0;
            qual_q    <= '0;
            retrain_q <= 1'b0;
            link_up_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bad_q     <= bad_d;
            hi_ber_q  <= hi_ber_d;
            tmo_q     <= tmo_d;
            qual_q    <= qual_d;
            retrain_q <= retrain_d;
            link_up_q <= link_up_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.o_state    = state_q;
    assign bus.o_link_up  = link_up_q;
    assign bus.o_hi_ber   = hi_ber_q;
    assign bus.o_retrain  = retrain_q;
    assign bus.o_drop_cnt = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_pcs_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_rx_link_ctrl
// Brief    : Directed + randomized bench for pcs_rx_link_ctrl with a reference model
// Revision : 1.0
// ============================================================================
module tb_pcs_rx_link_ctrl;
    localparam int HDR_WIDTH = 2;
    localparam int WIN       = 100;
    localparam int TH        = 4;
    localparam int LUP       = 8;
    localparam int TO        = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pcs_rx_link_ctrl_if #(.HDR_WIDTH(HDR_WIDTH)) bus ();

    pcs_rx_link_ctrl #(
        .HDR_WIDTH      (HDR_WIDTH),
        .BER_WINDOW_CYC (WIN),
        .BER_THRESH     (TH),
        .LINK_UP_HDRS   (LUP),
        .RETRAIN_TIMEOUT(TO)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: plain integers, window count is unbounded
    int m_state, m_tmr, m_bad, m_tmo, m_qual, m_drop;
    bit m_hiber, m_retrain;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input logic [HDR_WIDTH-1:0] hdr, input bit hv, input bit lk);
        int ps;
        bit phb, good, bad;
        if (r) begin
            m_state = 0; m_tmr = 0; m_bad = 0; m_hiber = 0;
            m_tmo = 0; m_qual = 0; m_retrain = 0; m_drop = 0;
            return;
        end
        ps   = m_state;
        phb  = m_hiber;
        good = hv && ($countones(hdr) % 2 == 1);
        bad  = hv && ($countones(hdr) % 2 == 0);
        if (!lk) begin
            m_tmr = 0; m_bad = 0; m_hiber = 0;
        end else begin
            m_bad += int'(bad);
            if (m_bad >= TH) m_hiber = 1;
            if (m_tmr == WIN - 1) begin
                m_hiber = (m_bad >= TH);
                m_bad   = 0;
                m_tmr   = 0;
            end else begin
                m_tmr++;
            end
        end
        m_retrain = 0;
        case (ps)
            0: begin m_state = 1; m_tmo = 0; end
            1: begin
                if (lk) begin m_state = 2; m_tmo = 0; end
                else if (m_tmo == TO - 1) begin m_retrain = 1; m_tmo = 0; end
                else m_tmo++;
            end
            2: begin
                if (!lk || phb) begin m_state = 1; m_qual = 0; end
                else if (good) begin
                    m_qual++;
                    if (m_qual == LUP) begin m_state = 3; m_qual = 0; end
                end
            end
            default: begin
                if (!lk || phb) begin
                    m_state = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("state",   32'(bus.o_state),    32'(m_state));
        check("link_up", 32'(bus.o_link_up),  32'(m_state == 3));
        check("hi_ber",  32'(bus.o_hi_ber),   32'(m_hiber));
        check("retrain", 32'(bus.o_retrain),  32'(m_retrain));
        check("drop",    32'(bus.o_drop_cnt), 32'(m_drop));
    endtask

    task automatic cyc(input bit r, input logic [HDR_WIDTH-1:0] hdr, input bit hv, input bit lk);
        rst              = r;
        bus.i_hdr        = hdr;
        bus.i_hdr_valid  = hv;
        bus.i_block_lock = lk;
        @(posedge clk);
        model_step(r, hdr, hv, lk);
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic bring_up();
        repeat (2) cyc(0, 2'b01, 1'b1, 1'b0);
        repeat (12) cyc(0, 2'b01, 1'b1, 1'b1);
        check("bring_up_state", 32'(bus.o_state), 32'd3);
    endtask

    initial begin
        int pulses, t1, t2, mode, len;
        logic [1:0] h;
        bit lk, hv;

        rst = 1'b1; bus.i_hdr = '0; bus.i_hdr_valid = 1'b0; bus.i_block_lock = 1'b0;

        // Reset values, then link bring-up with a clean stream
        cyc(1, 2'b01, 1'b1, 1'b1);
        check("rst_state", 32'(bus.o_state), 32'd0);
        check("rst_drop",  32'(bus.o_drop_cnt), 32'd0);
        cyc(0, 2'b01, 1'b1, 1'b1);
        check("up_seq_1", 32'(bus.o_state), 32'd1);
        cyc(0, 2'b01, 1'b1, 1'b1);
        check("up_seq_2", 32'(bus.o_state), 32'd2);
        repeat (7) cyc(0, 2'b01, 1'b1, 1'b1);
        check("up_seq_7good", 32'(bus.o_state), 32'd2);
        cyc(0, 2'b01, 1'b1, 1'b1);
        check("up_seq_3", 32'(bus.o_state), 32'd3);
        check("up_link", 32'(bus.o_link_up), 32'd1);

        // Four invalid headers in UP trip hi_ber and drop the link
        repeat (3) cyc(0, 2'b11, 1'b1, 1'b1);
        check("hiber_pre", 32'(bus.o_hi_ber), 32'd0);
        cyc(0, 2'b11, 1'b1, 1'b1);
        check("hiber_set", 32'(bus.o_hi_ber), 32'd1);
        check("hiber_still_up", 32'(bus.o_state), 32'd3);
        cyc(0, 2'b01, 1'b1, 1'b1);
        check("hiber_drop_state", 32'(bus.o_state), 32'd1);
        check("hiber_drop_cnt", 32'(bus.o_drop_cnt), 32'd1);

        // Accumulate three drops, then reset while UP
        bring_up();
        cyc(0, 2'b01, 1'b1, 1'b0);
        bring_up();
        cyc(0, 2'b01, 1'b1, 1'b0);
        bring_up();
        check("drop_before_rst", 32'(bus.o_drop_cnt), 32'd3);
        cyc(1, 2'b01, 1'b1, 1'b1);
        check("rst_mid_state", 32'(bus.o_state), 32'd0);
        check("rst_mid_drop", 32'(bus.o_drop_cnt), 32'd0);
        check("rst_mid_link", 32'(bus.o_link_up), 32'd0);
        cyc(0, 2'b01, 1'b1, 1'b1);
        check("rst_rel_state", 32'(bus.o_state), 32'd1);

        // No lock: retrain pulses every TO cycles, state parked in WAIT_LOCK
        cyc(1, 2'b01, 1'b0, 1'b0);
        pulses = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 120; i++) begin
            cyc(0, 2'b01, 1'b0, 1'b0);
            if (bus.o_retrain) begin
                pulses++;
                if (pulses == 1) t1 = i; else t2 = i;
            end
        end
        check("retrain_cnt", 32'(pulses), 32'd2);
        check("retrain_gap", 32'(t2 - t1), 32'(TO));
        check("retrain_state", 32'(bus.o_state), 32'd1);

        // Invalid header on the window-end cycle belongs only to the closing window
        cyc(1, 2'b01, 1'b1, 1'b0);
        cyc(0, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 130; i++) begin
            h = (i == 50 || i == 70 || i == 99 || i == 100) ? 2'b00 : 2'b10;
            cyc(0, h, 1'b1, 1'b1);
            if (i >= 95 && i <= 105) check("window_edge_hiber", 32'(bus.o_hi_ber), 32'd0);
        end

        // Lock loss mid-qualify restarts the good header count
        cyc(1, 2'b01, 1'b1, 1'b1);
        cyc(0, 2'b01, 1'b1, 1'b1);
        repeat (6) cyc(0, 2'b01, 1'b1, 1'b1);
        cyc(0, 2'b01, 1'b1, 1'b0);
        check("qual_abort_state", 32'(bus.o_state), 32'd1);
        cyc(0, 2'b01, 1'b1, 1'b1);
        repeat (7) cyc(0, 2'b01, 1'b1, 1'b1);
        check("requal_7", 32'(bus.o_state), 32'd2);
        cyc(0, 2'b01, 1'b1, 1'b1);
        check("requal_8", 32'(bus.o_state), 32'd3);

        // Randomized phases checked cycle-by-cycle against the model
        for (int p = 0; p < 40; p++) begin
            mode = $urandom_range(0, 4);
            len  = $urandom_range(20, 200);
            if (mode == 4) begin
                repeat ($urandom_range(1, 3)) cyc(1, good_hdr(), 1'b1, 1'b1);
            end
            for (int c = 0; c < len; c++) begin
                lk = 1'b1;
                hv = ($urandom_range(0, 9) != 0);
                h  = good_hdr();
                case (mode)
                    1: if ($urandom_range(0, 29) == 0) h = bad_hdr();
                    2: begin
                        lk = ($urandom_range(0, 15) != 0);
                        if ($urandom_range(0, 19) == 0) h = bad_hdr();
                    end
                    3: lk = 1'b0;
                    default: ;
                endcase
                cyc(0, h, hv, lk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pcs_rx_link_ctrl.md
PCS_RX_LINK_CTRL -- requirements
Module: pcs_rx_link_ctrl

Interface
REQ-001 Parameter HDR_WIDTH, default 2, sync header width.
REQ-002 Parameter BER_WINDOW_CYC, default 19531, BER window length in clock cycles (125 us at 156.25 MHz).
REQ-003 Parameter BER_THRESH, default 16, invalid headers per window that assert hi_ber.
REQ-004 Parameter LINK_UP_HDRS, default 1024, valid headers required while locked before link up.
REQ-005 Parameter RETRAIN_TIMEOUT, default 65536, cycles in WAIT_LOCK before a retrain pulse.
REQ-006 i_clk  input  1  sole clock; all logic on rising edge.
REQ-007 i_reset  input  1  reset, synchronous and active-high.
REQ-008 i_hdr  input  HDR_WIDTH  sync header from rx block sync.
REQ-009 i_hdr_valid  input  1  i_hdr qualifier.
REQ-010 i_block_lock  input  1  block lock from lock state machine.
REQ-011 o_state  output  2  FSM state: 0 DOWN, 1 WAIT_LOCK, 2 QUALIFY, 3 UP.
REQ-012 o_link_up  output  1  high only in UP.
REQ-013 o_hi_ber  output  1  high bit error ratio flag.
REQ-014 o_retrain  output  1  one-cycle pulse requesting block sync realignment.
REQ-015 o_drop_cnt  output  8  saturating count of UP exits.

Function
REQ-016 Header valid (sh_valid) is the XOR-reduction of i_hdr; "invalid header" means i_hdr_valid=1 and sh_valid=0; "good header" means i_hdr_valid=1 and sh_valid=1.
REQ-017 BER window timer increments every cycle while i_block_lock=1 and wraps to 0 after BER_WINDOW_CYC-1.
REQ-018 BER invalid counter increments on each invalid header while i_block_lock=1 and saturates at BER_THRESH.
REQ-019 o_hi_ber rises the cycle after the invalid counter reaches BER_THRESH, mid-window, without waiting for window end.
REQ-020 At window end (timer = BER_WINDOW_CYC-1), the count including any invalid header on that cycle is evaluated; o_hi_ber clears next cycle if it is below BER_THRESH, else stays set; counter clears to 0.
REQ-021 An invalid header on the window-end cycle is counted only in the closing window, never in the next.
REQ-022 While i_block_lock=0, the timer, invalid counter and o_hi_ber are forced to 0 the next cycle.
REQ-023 DOWN: entered on reset; unconditional transition to WAIT_LOCK next cycle.
REQ-024 WAIT_LOCK: timeout counter increments each cycle; i_block_lock=1 -> QUALIFY with counter cleared.
REQ-025 WAIT_LOCK timeout: when the counter reaches RETRAIN_TIMEOUT-1, o_retrain pulses for exactly one cycle, the counter restarts at 0 and state stays WAIT_LOCK; lock and timeout on the same cycle -> QUALIFY and no pulse.
REQ-026 QUALIFY: qualify counter counts good headers; i_block_lock=0 or o_hi_ber=1 -> WAIT_LOCK with counter cleared; the good header bringing the count to LINK_UP_HDRS -> UP next cycle.
REQ-027 In QUALIFY, loss of lock or hi_ber takes priority over completing qualification on the same cycle.
REQ-028 UP: i_block_lock=0 or o_hi_ber=1 -> WAIT_LOCK next cycle, o_drop_cnt increments, holding at 255.
REQ-029 o_link_up and o_state are registered and reflect the current state; no combinational input-to-output path.
REQ-030 Counter widths are $clog2 of their terminal value plus 1; no counter may wrap unintentionally.

Reset
REQ-031 While i_reset=1: state DOWN, o_state=0, o_link_up=0, o_hi_ber=0, o_retrain=0, o_drop_cnt=0, all internal counters 0.
REQ-032 Reset asserted in any state, mid-window or mid-qualify, takes effect on the next edge and discards all accumulated counts.
REQ-033 First cycle after reset release is DOWN; WAIT_LOCK follows one cycle later.

Verification (BER_WINDOW_CYC=100, BER_THRESH=4, LINK_UP_HDRS=8, RETRAIN_TIMEOUT=50)
REQ-034 Release reset, hold i_block_lock=1, valid 2'b01 every cycle -> o_state 0,1,2 then 3 the cycle after the 8th good header; o_link_up=1.
REQ-035 Hold i_block_lock=0 for 120 cycles after reset -> o_retrain pulses, one cycle wide, at 50-cycle spacing; o_state stays 1.
REQ-036 In UP, 4 headers of 2'b11 within one window -> o_hi_ber=1 the cycle after the 4th; state 1 next cycle; o_drop_cnt=1.
REQ-037 3 invalid headers in window N, 3rd on final cycle, plus 1 at window N+1 cycle 0 -> o_hi_ber never asserts.
REQ-038 In QUALIFY after 5 good headers, drop i_block_lock one cycle -> state 1; relock needs 8 new good headers before UP.
REQ-039 Assert i_reset for one cycle while UP with o_drop_cnt=3 -> all outputs 0 next cycle, o_state 0 then 1.
